// File: rtl/cnn_defines.sv
// rtl/cnn_defines.sv - shared CNN geometry constants and conv1 controller state encoding
package cnn_defines;

  localparam int DEF_IMG_IN_WIDTH  = 28;
  localparam int DEF_KERNEL_WIDTH  = 5;
  localparam int DEF_DRAIN_TIMEOUT = 16;

  // Pixels in one square input frame.
  function automatic int pix_count(input int img_w);
    return img_w * img_w;
  endfunction

  // Results of a valid (no padding, stride 1) convolution over one frame.
  function automatic int res_count(input int img_w, input int kern_w);
    return (img_w - kern_w + 1) * (img_w - kern_w + 1);
  endfunction

  localparam int DEF_PIX_CNT = DEF_IMG_IN_WIDTH * DEF_IMG_IN_WIDTH;
  localparam int DEF_RES_CNT = (DEF_IMG_IN_WIDTH - DEF_KERNEL_WIDTH + 1) *
                               (DEF_IMG_IN_WIDTH - DEF_KERNEL_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } conv1_state_t;

endpackage

// File: rtl/conv1_ctrl.sv
// rtl/conv1_ctrl.sv - frame sequencer feeding image RAM pixels into conv1 and counting its results
import cnn_defines::*;

module conv1_ctrl #(
  parameter int IMG_IN_WIDTH  = DEF_IMG_IN_WIDTH,
  parameter int KERNEL_WIDTH  = DEF_KERNEL_WIDTH,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hold,
  output logic       img_rd_en,
  output logic [9:0] img_raddr,
  input  logic [7:0] img_rdata,
  output logic [7:0] cnn_data_in,
  output logic       cnn_data_in_valid,
  output logic       img_in_en,
  input  logic       cnn_data_out_valid,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [9:0] res_cnt
);

  localparam logic [9:0] LAST_ADDR = 10'(pix_count(IMG_IN_WIDTH) - 1);
  localparam logic [9:0] RES_MAX   = 10'(res_count(IMG_IN_WIDTH, KERNEL_WIDTH));
  localparam int         DW        = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

  conv1_state_t  state;
  logic [DW-1:0] drain_cnt;
  logic          frame_live;
  logic          res_inc;
  logic          res_hit;
  logic          drain_exp;

  // A read goes out every FEED cycle unless the consumer asks us to hold off.
  assign img_rd_en   = (state == ST_FEED) && !hold;
  // RAM data is already aligned with the delayed valid; zero it when idle so nothing leaks out.
  assign cnn_data_in = cnn_data_in_valid ? img_rdata : 8'd0;
  assign frame_live  = (state == ST_FEED) || (state == ST_DRAIN);
  // The last pixel lands one cycle after FEED ends, so keep the layer enabled for it.
  assign img_in_en   = frame_live || cnn_data_in_valid;

  assign res_inc   = frame_live && cnn_data_out_valid && (res_cnt != RES_MAX);
  // Completion counts the very cycle the final result arrives, not only the cycle after.
  assign res_hit   = (res_cnt == RES_MAX) || (res_inc && (res_cnt == RES_MAX - 10'd1));
  assign drain_exp = !cnn_data_out_valid && (drain_cnt == DRAIN_LAST);

  // Pixel valid trails the read enable by the RAM's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnn_data_in_valid <= 1'b0;
    end else begin
      cnn_data_in_valid <= img_rd_en;
    end
  end

  // Frame sequencer: address generation, result counting, drain watchdog and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      img_raddr <= 10'd0;
      res_cnt   <= 10'd0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (res_inc) begin
        res_cnt <= res_cnt + 10'd1;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FEED;
            img_raddr <= 10'd0;
            res_cnt   <= 10'd0;
            drain_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        ST_FEED: begin
          if (img_rd_en) begin
            if (img_raddr == LAST_ADDR) begin
              state <= ST_DRAIN;
            end else begin
              img_raddr <= img_raddr + 10'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (res_hit) begin
            state <= ST_FIN;
            done  <= 1'b1;
          end else if (drain_exp) begin
            state <= ST_FIN;
            err   <= 1'b1;
          end else if (cnn_data_out_valid) begin
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv1_ctrl.sv
// tb/tb_conv1_ctrl.sv - randomized self-checking bench for conv1_ctrl with image RAM and conv layer models
module tb_conv1_ctrl;

  localparam int W    = 28;
  localparam int K    = 5;
  localparam int DT   = 16;
  localparam int NPIX = W * W;
  localparam int NRES = (W - K + 1) * (W - K + 1);
  localparam int LAT  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic       img_rd_en;
  logic [9:0] img_raddr;
  logic [7:0] img_rdata = 8'd0;
  logic [7:0] cnn_data_in;
  logic       cnn_data_in_valid;
  logic       img_in_en;
  logic       cnn_data_out_valid = 1'b0;
  logic       busy;
  logic       done;
  logic       err;
  logic [9:0] res_cnt;

  always #5 clk = ~clk;

  conv1_ctrl #(.IMG_IN_WIDTH(W), .KERNEL_WIDTH(K), .DRAIN_TIMEOUT(DT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .img_rd_en(img_rd_en), .img_raddr(img_raddr), .img_rdata(img_rdata),
    .cnn_data_in(cnn_data_in), .cnn_data_in_valid(cnn_data_in_valid),
    .img_in_en(img_in_en), .cnn_data_out_valid(cnn_data_out_valid),
    .busy(busy), .done(done), .err(err), .res_cnt(res_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Image RAM: one-cycle registered read.
  logic [7:0] mem [NPIX];
  always @(posedge clk) begin
    if (img_rd_en) img_rdata <= mem[img_raddr];
  end

  // Reference bookkeeping, updated away from the active edge.
  int cyc = 0;
  int exp_addr, exp_pix, reads, res_seen, n_done, n_err;
  int first_rd_cyc, last_rd_cyc, last_res_cyc, done_cyc, err_cyc, done_res, err_res;
  bit conv_on = 1'b1;
  logic [LAT-1:0] pipe = '0;

  // Monitor plus conv layer stand-in: a result appears LAT cycles after every pixel
  // whose kernel window fits entirely inside the image.
  always @(negedge clk) begin
    bit prod;
    cyc++;
    prod = 1'b0;
    if (!rst_n) begin
      pipe = '0;
      cnn_data_out_valid = 1'b0;
    end else begin
      if (img_rd_en) begin
        check("raddr", int'(img_raddr), exp_addr);
        if (reads == 0) first_rd_cyc = cyc;
        last_rd_cyc = cyc;
        exp_addr++;
        reads++;
      end
      if (cnn_data_in_valid) begin
        check("pixel", int'(cnn_data_in), int'(mem[exp_pix % NPIX]));
        prod = ((exp_pix / W) >= K - 1) && ((exp_pix % W) >= K - 1);
        exp_pix++;
      end
      if (done) begin n_done++; done_cyc = cyc; done_res = int'(res_cnt); end
      if (err)  begin n_err++;  err_cyc = cyc;  err_res = int'(res_cnt);  end
      pipe = {pipe[LAT-2:0], prod & conv_on};
      cnn_data_out_valid = pipe[LAT-1];
      if (pipe[LAT-1]) begin res_seen++; last_res_cyc = cyc; end
    end
  end

  // mode 0: no stall, 1: 10-cycle hold at address 100, 2: random hold, 3: extra start at address 300
  task automatic run_frame(input int mode, input bit conv_en, input bit expect_done);
    int hold_left;
    bit used;
    int span;
    hold_left = 0;
    used = 1'b0;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    conv_on = conv_en;
    exp_addr = 0; exp_pix = 0; reads = 0; res_seen = 0; n_done = 0; n_err = 0;
    done_cyc = 0; err_cyc = 0; done_res = -1; err_res = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_on", int'(busy), 1);
    check("res_clr", int'(res_cnt), 0);
    for (int t = 0; t < 4000 && n_done == 0 && n_err == 0; t++) begin
      start = 1'b0;
      if (mode == 1) begin
        if (hold_left > 0) begin
          hold_left--;
          if (hold_left == 0) begin
            hold = 1'b0;
            check("hold_addr", int'(img_raddr), 100);
          end
        end else if (!used && img_raddr == 10'd100) begin
          hold = 1'b1; hold_left = 10; used = 1'b1;
        end
      end else if (mode == 2) begin
        hold = (busy && ($urandom % 4 == 0));
      end else if (mode == 3) begin
        if (!used && img_raddr == 10'd300) begin start = 1'b1; used = 1'b1; end
      end
      @(posedge clk); #1;
    end
    hold = 1'b0;
    start = 1'b0;
    if (n_done == 0 && n_err == 0) check("frame_end_seen", 0, 1);
    check("reads", reads, NPIX);
    check("pixels", exp_pix, NPIX);
    span = last_rd_cyc - first_rd_cyc + 1;
    if (mode == 0) check("read_span", span, NPIX);
    if (mode == 1) check("hold_span", span, NPIX + 10);
    if (expect_done) begin
      check("done_cnt", n_done, 1);
      check("err_cnt", n_err, 0);
      check("res_seen", res_seen, NRES);
      check("done_res", done_res, NRES);
      check("done_lat", done_cyc - last_res_cyc, 1);
    end else begin
      check("err_cnt", n_err, 1);
      check("done_cnt", n_done, 0);
      check("err_lat", err_cyc - last_rd_cyc, DT + 1);
      check("err_res", err_res, 0);
    end
    check("busy_off", int'(busy), 0);
    check("in_en_off", int'(img_in_en), 0);
  endtask

  task automatic reset_mid_frame();
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    conv_on = 1'b1;
    exp_addr = 0; exp_pix = 0; reads = 0; res_seen = 0; n_done = 0; n_err = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 2000 && img_raddr != 10'd500; t++) begin
      @(posedge clk); #1;
    end
    check("rst_reach", int'(img_raddr), 500);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd_en", int'(img_rd_en), 0);
    check("rst_valid", int'(cnn_data_in_valid), 0);
    check("rst_in_en", int'(img_in_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_raddr", int'(img_raddr), 0);
    check("rst_res", int'(res_cnt), 0);
    check("rst_data", int'(cnn_data_in), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      check("post_rst_idle", int'(img_rd_en), 0);
      check("post_rst_busy", int'(busy), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("init_busy", int'(busy), 0);
    check("init_rd_en", int'(img_rd_en), 0);
    check("init_raddr", int'(img_raddr), 0);
    check("init_res", int'(res_cnt), 0);
    check("init_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_no_read", int'(img_rd_en), 0);
    end
    run_frame(0, 1'b1, 1'b1);
    run_frame(0, 1'b1, 1'b1);
    run_frame(1, 1'b1, 1'b1);
    run_frame(2, 1'b1, 1'b1);
    run_frame(3, 1'b1, 1'b1);
    run_frame(0, 1'b0, 1'b0);
    run_frame(2, 1'b1, 1'b1);
    reset_mid_frame();
    run_frame(0, 1'b1, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
